// File: rtl/sobel_stream_filter.sv
// Streaming 3x3 Sobel edge filter: raster-order pixels in, registered gx/gy/|gx|+|gy|
// and a thresholded edge flag out for every interior pixel, with a single-entry output register.
module sobel_stream_filter #(
  parameter int PIXEL_W = 8,
  parameter int IMG_W   = 64,
  localparam int RES_W  = PIXEL_W + 3,
  localparam int LW_W   = $clog2(IMG_W + 1)
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    clear_i,
  input  logic [LW_W-1:0]         line_width_i,
  input  logic [RES_W-1:0]        threshold_i,
  input  logic                    use_threshold_i,
  input  logic                    pix_valid_i,
  output logic                    pix_ready_o,
  input  logic [PIXEL_W-1:0]      pix_data_i,
  output logic                    out_valid_o,
  input  logic                    out_ready_i,
  output logic signed [RES_W-1:0] gx_o,
  output logic signed [RES_W-1:0] gy_o,
  output logic [RES_W-1:0]        mag_o,
  output logic                    edge_o,
  output logic [15:0]             row_o,
  output logic [15:0]             col_o
);

  localparam int AW = $clog2(IMG_W);

  typedef logic signed [RES_W-1:0] res_t;

  logic [PIXEL_W-1:0] lb0 [IMG_W];
  logic [PIXEL_W-1:0] lb1 [IMG_W];
  // Only the two newest window columns are stored; the third is the incoming pixel column.
  logic [PIXEL_W-1:0] win [3][2];
  logic [AW-1:0]      col_q;
  logic [15:0]        row_q;

  logic [15:0]        w_eff;
  logic [15:0]        col_ext;
  logic               accept;
  logic               last_col;
  logic               win_valid;
  logic [PIXEL_W-1:0] top_new;
  logic [PIXEL_W-1:0] mid_new;
  res_t               gx_c;
  res_t               gy_c;
  logic [RES_W-1:0]   abs_gx;
  logic [RES_W-1:0]   abs_gy;
  logic [RES_W-1:0]   mag_c;
  logic               edge_c;

  function automatic res_t ext(input logic [PIXEL_W-1:0] p);
    return res_t'({3'b000, p});
  endfunction

  assign pix_ready_o = !out_valid_o || out_ready_i;

  always_comb begin
    w_eff = 16'(line_width_i);
    if (line_width_i == '0 || 16'(line_width_i) > 16'(IMG_W)) begin
      w_eff = 16'(IMG_W);
    end
    col_ext   = 16'(col_q);
    accept    = pix_valid_i && pix_ready_o && !clear_i;
    last_col  = (col_ext + 16'd1) >= w_eff;
    win_valid = (row_q >= 16'd2) && (col_ext >= 16'd2);
    top_new   = lb1[col_q];
    mid_new   = lb0[col_q];

    // Window after the shift: columns {win[*][0], win[*][1], new}.
    gx_c = (ext(top_new) + (ext(mid_new) <<< 1) + ext(pix_data_i))
         - (ext(win[0][0]) + (ext(win[1][0]) <<< 1) + ext(win[2][0]));
    gy_c = (ext(win[2][0]) + (ext(win[2][1]) <<< 1) + ext(pix_data_i))
         - (ext(win[0][0]) + (ext(win[0][1]) <<< 1) + ext(top_new));
    abs_gx = gx_c[RES_W-1] ? -gx_c : gx_c;
    abs_gy = gy_c[RES_W-1] ? -gy_c : gy_c;
    mag_c  = abs_gx + abs_gy;
    edge_c = use_threshold_i && (mag_c > threshold_i);
  end

  always_ff @(posedge clk_i) begin
    if (accept) begin
      lb1[col_q] <= mid_new;
      lb0[col_q] <= pix_data_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      col_q <= '0;
      row_q <= '0;
      for (int unsigned i = 0; i < 3; i++) begin
        win[i][0] <= '0;
        win[i][1] <= '0;
      end
    end else if (clear_i) begin
      col_q <= '0;
      row_q <= '0;
      for (int unsigned i = 0; i < 3; i++) begin
        win[i][0] <= '0;
        win[i][1] <= '0;
      end
    end else if (accept) begin
      for (int unsigned i = 0; i < 3; i++) begin
        win[i][0] <= win[i][1];
      end
      win[0][1] <= top_new;
      win[1][1] <= mid_new;
      win[2][1] <= pix_data_i;
      if (last_col) begin
        col_q <= '0;
        if (row_q != 16'hFFFF) begin
          row_q <= row_q + 16'd1;
        end
      end else begin
        col_q <= col_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      out_valid_o <= 1'b0;
      gx_o        <= '0;
      gy_o        <= '0;
      mag_o       <= '0;
      edge_o      <= 1'b0;
      row_o       <= '0;
      col_o       <= '0;
    end else if (clear_i) begin
      out_valid_o <= 1'b0;
    end else if (accept && win_valid) begin
      out_valid_o <= 1'b1;
      gx_o        <= gx_c;
      gy_o        <= gy_c;
      mag_o       <= mag_c;
      edge_o      <= edge_c;
      row_o       <= row_q - 16'd1;
      col_o       <= col_ext - 16'd1;
    end else if (out_valid_o && out_ready_i) begin
      out_valid_o <= 1'b0;
    end
  end

endmodule

// File: tb/tb_sobel_stream_filter.sv
// Bench for sobel_stream_filter: directed frames checked against a direct 3x3 convolution
// model of the image, plus literal pins on selected results.
module tb_sobel_stream_filter;
  localparam int PW = 8;
  localparam int IW = 64;
  localparam int RW = PW + 3;
  localparam int LW = $clog2(IW + 1);

  logic                 clk;
  logic                 rst_n;
  logic                 clear;
  logic [LW-1:0]        line_width;
  logic [RW-1:0]        threshold;
  logic                 use_thr;
  logic                 pix_valid;
  logic                 pix_ready;
  logic [PW-1:0]        pix_data;
  logic                 out_valid;
  logic                 out_ready;
  logic signed [RW-1:0] gx;
  logic signed [RW-1:0] gy;
  logic [RW-1:0]        mag;
  logic                 edge_f;
  logic [15:0]          row;
  logic [15:0]          col;

  sobel_stream_filter #(.PIXEL_W(PW), .IMG_W(IW)) dut (
    .clk_i(clk), .rst_ni(rst_n), .clear_i(clear), .line_width_i(line_width),
    .threshold_i(threshold), .use_threshold_i(use_thr),
    .pix_valid_i(pix_valid), .pix_ready_o(pix_ready), .pix_data_i(pix_data),
    .out_valid_o(out_valid), .out_ready_i(out_ready),
    .gx_o(gx), .gy_o(gy), .mag_o(mag), .edge_o(edge_f), .row_o(row), .col_o(col)
  );

  typedef struct {
    int gx;
    int gy;
    int mag;
    int edg;
    int row;
    int col;
  } res_s;

  res_s exp_q[$];
  res_s log_a[$];
  res_s cur;
  res_s e;
  res_s snap;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int first_v = -1;
  int acc22 = -2;
  int stall = 0;
  bit bp_arm = 0;
  bit hold_req = 0;
  bit stall_prev = 0;
  bit clr_prev = 0;

  task automatic chk(input string nm, input int act, input int expv);
    n_cmp++;
    if (act != expv) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, expv, $time);
    end
  endtask

  function automatic int pix_val(input int pat, input int r, input int c);
    case (pat)
      0:       return 50;
      1:       return (c < 4) ? 0 : 100;
      2:       return (r < 2) ? 0 : 255;
      default: return c;
    endcase
  endfunction

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  // Expected results: every interior centre whose bottom-right pixel is among the first nexp pixels.
  task automatic build_expect(input int pat, input int w, input int h, input int nexp,
                              input int thr, input int ut);
    res_s x;
    int p [3][3];
    for (int r = 1; r <= h - 2; r++) begin
      for (int c = 1; c <= w - 2; c++) begin
        if ((r + 1) * w + (c + 1) < nexp) begin
          for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++)
              p[i][j] = pix_val(pat, r - 1 + i, c - 1 + j);
          x.gx  = (p[0][2] + 2 * p[1][2] + p[2][2]) - (p[0][0] + 2 * p[1][0] + p[2][0]);
          x.gy  = (p[2][0] + 2 * p[2][1] + p[2][2]) - (p[0][0] + 2 * p[0][1] + p[0][2]);
          x.mag = iabs(x.gx) + iabs(x.gy);
          x.edg = (ut != 0 && x.mag > thr) ? 1 : 0;
          x.row = r;
          x.col = c;
          exp_q.push_back(x);
        end
      end
    end
  endtask

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc = cyc + 1;

  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      if (bp_arm && out_valid) begin
        bp_arm = 0;
        stall  = 5;
      end
      if (stall > 0) begin
        out_ready = 1'b0;
        stall--;
      end else begin
        out_ready = !hold_req;
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      cur.gx = int'(gx); cur.gy = int'(gy); cur.mag = int'(mag);
      cur.edg = int'(edge_f); cur.row = int'(row); cur.col = int'(col);
      if (out_valid && first_v < 0) first_v = cyc;
      if (stall_prev && !clr_prev) begin
        chk("stall_valid", int'(out_valid), 1);
        chk("stall_gx", cur.gx, snap.gx);
        chk("stall_mag", cur.mag, snap.mag);
        chk("stall_row", cur.row, snap.row);
        chk("stall_col", cur.col, snap.col);
      end
      if (out_valid && !out_ready) chk("stall_pix_ready", int'(pix_ready), 0);
      if (out_valid && out_ready) begin
        log_a.push_back(cur);
        if (exp_q.size() == 0) begin
          chk("unexpected_result_row", cur.row, -1);
        end else begin
          e = exp_q.pop_front();
          chk("res_row", cur.row, e.row);
          chk("res_col", cur.col, e.col);
          chk("res_gx", cur.gx, e.gx);
          chk("res_gy", cur.gy, e.gy);
          chk("res_mag", cur.mag, e.mag);
          chk("res_edge", cur.edg, e.edg);
        end
      end
      stall_prev = out_valid && !out_ready;
      clr_prev   = clear;
      snap       = cur;
    end
  end

  task automatic send(input int d);
    int g;
    pix_data  = PW'(d);
    pix_valid = 1'b1;
    g = 0;
    @(negedge clk);
    while (!pix_ready && g < 1000) begin
      @(negedge clk);
      g++;
    end
    if (g >= 1000) chk("send_timeout", g, 0);
    @(posedge clk);
    #1;
  endtask

  task automatic do_clear();
    pix_valid = 1'b0;
    clear = 1'b1;
    @(posedge clk);
    #1;
    clear = 1'b0;
  endtask

  task automatic run_frame(input int pat, input int lw, input int w, input int h,
                           input int nsend, input int nexp, input int thr, input int ut);
    line_width = LW'(lw);
    threshold  = RW'(thr);
    use_thr    = (ut != 0);
    do_clear();
    log_a.delete();
    first_v = -1;
    acc22   = -2;
    build_expect(pat, w, h, nexp, thr, ut);
    for (int r = 0; r < h; r++) begin
      for (int c = 0; c < w; c++) begin
        if (r * w + c < nsend) begin
          send(pix_val(pat, r, c));
          if (r == 2 && c == 2) acc22 = cyc;
        end
      end
    end
    pix_valid = 1'b0;
  endtask

  task automatic drain();
    int g;
    g = 0;
    while (exp_q.size() != 0 && g < 500) begin
      @(negedge clk);
      g++;
    end
    repeat (3) @(negedge clk);
    chk("drain_left", exp_q.size(), 0);
    exp_q.delete();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; clear = 1'b0; line_width = LW'(8); threshold = '0; use_thr = 1'b0;
    pix_valid = 1'b0; pix_data = '0;
    repeat (3) @(negedge clk);
    chk("rst_valid", int'(out_valid), 0);
    chk("rst_gx", int'(gx), 0);
    chk("rst_gy", int'(gy), 0);
    chk("rst_mag", int'(mag), 0);
    chk("rst_edge", int'(edge_f), 0);
    chk("rst_row", int'(row), 0);
    chk("rst_col", int'(col), 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    run_frame(0, 8, 8, 4, 32, 32, 0, 0);
    drain();
    chk("flat_count", log_a.size(), 12);
    chk("flat_latency", first_v, acc22);
    chk("flat_first_mag", log_a[0].mag, 0);

    run_frame(1, 8, 8, 4, 32, 32, 100, 1);
    drain();
    chk("vert_c3_gx", log_a[2].gx, 400);
    chk("vert_c3_edge", log_a[2].edg, 1);
    chk("vert_c4_mag", log_a[3].mag, 400);
    chk("vert_c1_edge", log_a[0].edg, 0);

    run_frame(2, 8, 8, 4, 32, 32, 0, 0);
    drain();
    chk("horiz_first_gy", log_a[0].gy, 1020);
    chk("horiz_last_row", log_a[11].row, 2);
    chk("horiz_last_edge", log_a[11].edg, 0);

    bp_arm = 1;
    run_frame(0, 8, 8, 4, 32, 32, 0, 0);
    drain();
    chk("bp_count", log_a.size(), 12);

    // Last result (from pixel (2,4)) is held by the sink and must be dropped by clear.
    run_frame(1, 8, 8, 4, 21, 20, 100, 1);
    hold_req = 1;
    clear = 1'b1;
    @(posedge clk);
    #1;
    clear = 1'b0;
    hold_req = 0;
    @(negedge clk);
    chk("clear_drops_valid", int'(out_valid), 0);
    chk("clear_prior_results", log_a.size(), 2);
    drain();
    run_frame(0, 8, 8, 4, 32, 32, 0, 0);
    drain();
    chk("after_clear_row", log_a[0].row, 1);
    chk("after_clear_col", log_a[0].col, 1);
    chk("after_clear_count", log_a.size(), 12);

    run_frame(3, 0, 64, 3, 192, 192, 0, 0);
    drain();
    chk("ramp_count", log_a.size(), 62);
    chk("ramp_first_gx", log_a[0].gx, 8);
    chk("ramp_last_col", log_a[61].col, 62);

    run_frame(0, 2, 2, 4, 8, 8, 0, 0);
    drain();
    chk("narrow_count", log_a.size(), 0);

    do_clear();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/sobel_stream_filter.md
Name: sobel_stream_filter

Overview:
- Streaming 3x3 Sobel edge filter. Accepts one raster-order grayscale pixel per handshake and keeps two line buffers plus a 3x3 window.
- Emits registered gx, gy, |gx|+|gy| and a thresholded edge flag for every interior pixel.
- Parametrised successor to the combinational Sobel kernel: adds pixel width, line length and runtime threshold/width control.
- Sits in the user domain between the pixel DMA/source and the result sink.

Parameters:
- PIXEL_W, 8, unsigned grayscale pixel width (4..12).
- IMG_W, 64, maximum line length in pixels; sets line buffer depth (>=3).
- RES_W, PIXEL_W+3, width of gx/gy (signed) and magnitude (unsigned). Derived; must not be overridden.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  asynchronous active-low reset.
- clear_i  in  1  synchronous frame restart: zero counters and window, drop pending output.
- line_width_i  in  $clog2(IMG_W+1)  active line length; stable while a frame is in progress.
- threshold_i  in  RES_W  edge threshold, unsigned.
- use_threshold_i  in  1  enable edge_o generation.
- pix_valid_i  in  1  input pixel valid.
- pix_ready_o  out  1  filter can accept a pixel.
- pix_data_i  in  PIXEL_W  unsigned pixel.
- out_valid_o  out  1  result valid.
- out_ready_i  in  1  sink accepts result.
- gx_o  out  RES_W  signed horizontal gradient.
- gy_o  out  RES_W  signed vertical gradient.
- mag_o  out  RES_W  |gx|+|gy|, unsigned.
- edge_o  out  1  use_threshold_i && mag_o > threshold_i, registered with the result.
- row_o  out  16  image row of the result's centre pixel.
- col_o  out  16  image column of the result's centre pixel.

Behaviour:
- Reset (rst_ni=0, async):
  - out_valid_o=0; gx_o, gy_o, mag_o, edge_o, row_o, col_o = 0.
  - Column/row counters = 0; window registers = 0.
  - Line buffer contents are don't-care.
- Effective width W:
  - W = line_width_i, except 0 or >IMG_W gives W = IMG_W.
  - W < 3 produces no outputs; pixels are still consumed.
- Handshakes:
  - Input accept = pix_valid_i && pix_ready_o.
  - pix_ready_o = !out_valid_o || out_ready_i (combinational; single output register).
  - Output transfer = out_valid_o && out_ready_i.
  - While out_valid_o && !out_ready_i, every output port holds stable.
- On each input accept at position (r, c):
  - New window column = {top: lb1[c], mid: lb0[c], bottom: pix}.
  - Shift the window left by one column, then write lb1[c] <= lb0[c] and lb0[c] <= pix.
  - c increments and wraps to 0 after W-1. On wrap, r increments, saturating at 0xFFFF.
- Window validity:
  - A window is valid when r >= 2 && c >= 2 (c is the pre-increment column).
  - Its centre is at (r-1, c-1).
  - Windows straddling a line wrap are never flagged valid.
- Output latency:
  - A valid-window accept loads the output register on the same clock edge; out_valid_o rises the next cycle.
  - Throughput is 1 result/cycle when out_ready_i=1.
  - An accept without a valid window: out_valid_o <= 0 if the current output transferred this cycle, otherwise it holds.
- Arithmetic: pixels are zero-extended to RES_W signed.
  - gx = (p02 + 2*p12 + p22) - (p00 + 2*p10 + p20).
  - gy = (p20 + 2*p21 + p22) - (p00 + 2*p01 + p02).
  - mag = |gx| + |gy|.
  - RES_W bits suffice at extremes (PIXEL_W=8: |gx| <= 1020, mag <= 2040). No saturation.
- Result count: a frame of H rows yields (W-2)*(H-2) results. There is no frame end marker; clear_i starts a new frame.
- threshold_i and use_threshold_i are sampled when the result register loads.
- clear_i:
  - Takes priority over a same-cycle input accept; that pixel is dropped and pix_ready_o is unaffected.
  - Forces out_valid_o=0 next cycle.
- Asynchronous reset mid-frame discards all state. The next pixel is treated as (0,0).

Test Plan:
- Flat image, W=8, 4 rows, all pixels 50, sink always ready -> exactly 12 results, all gx=gy=mag=0, edge_o=0; first out_valid_o one cycle after accepting pixel (2,2).
- Vertical step, W=8, 4 rows, cols 0-3 = 0 and cols 4-7 = 100, threshold 100, use_threshold=1 -> results with col_o=3 and col_o=4 give gx=400, gy=0, mag=400, edge_o=1; all other columns give 0/0/0, edge_o=0.
- Horizontal step (rows 0-1 = 0, rows 2-3 = 255, PIXEL_W=8) -> row_o=1 and row_o=2 give gy=1020, gx=0, mag=1020; use_threshold=0 -> edge_o=0 everywhere.
- Backpressure: hold out_ready_i=0 for 5 cycles after the first result -> pix_ready_o=0, outputs stable; release -> no result lost or duplicated, total still 12.
- clear_i asserted mid-row 2, then a fresh flat frame -> no stale results; first new result has row_o=1, col_o=1.
- line_width_i=0 with IMG_W=64, 3 rows of ramp pix=col -> 62 results, gx=8, gy=0, mag=8.
